add_sub_pipe: RTL and testbench
===============================

Name: add_sub_pipe

Overview:
- Parametrised, pipelined integer adder/subtractor for the ALU datapath; successor to the single-cycle 32-bit flagged adder.
- Splits the carry chain into STAGES segments, one register stage per segment.
- Adds subtract and saturate modes and a valid/ready handshake with backpressure.
- Produces Zero, Overflow and Negative flags for signed and unsigned operands.

Parameters:
- WIDTH, 32, operand/result width; must be divisible by STAGES.
- STAGES, 2, number of carry segments and pipeline registers (1..8); latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Signed  in  1  1 = two's-complement operands; 0 = unsigned.
- Sub  in  1  1 = A-B; 0 = A+B.
- Sat  in  1  1 = saturate result on overflow.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  result.
- Zero  out  1  S == 0 (final, post-saturation S).
- Overflow  out  1  true result not representable.
- Negative  out  1  true mathematical result < 0.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits cleared; out_valid=0, S=0, Zero=0, Overflow=0, Negative=0. In-flight beats are discarded. in_ready=1 one cycle after rst_n deasserts.
- Advance enable: adv = ~out_valid | out_ready.
  - All stages shift together when adv=1, so in_ready = adv.
  - Input accepted when in_valid & in_ready.
  - Bubbles propagate as valid=0.
- Latency: an accepted beat appears on the outputs exactly STAGES cycles later if never stalled.
  - While out_valid=1 & out_ready=0, the outputs hold stable and no beat is lost or duplicated.
  - Throughput: 1 beat/cycle.
- Arithmetic:
  - Beff = Sub ? ~B : B; cin = Sub.
  - Stage k adds bits [k*W/STAGES +: W/STAGES] with the carry registered from stage k-1.
  - Unconsumed upper operand bits and Signed/Sub/Sat travel with the beat.
  - Raw sum R, carry-out C.
- Overflow:
  - Signed: (A[msb]==Beff[msb]) & (R[msb]!=A[msb]).
  - Unsigned add: C. Unsigned sub: ~C (borrow, A<B).
- Negative:
  - Signed: (A[msb]^Beff[msb]) ? R[msb] : A[msb], correct even on overflow.
  - Unsigned add: 0. Unsigned sub: ~C.
- Saturation (Sat=1 & Overflow=1):
  - Signed: S = Negative ? min (1 followed by 0s) : max (0 followed by 1s).
  - Unsigned add: all ones. Unsigned sub: 0.
  - Otherwise S = R.
  - Overflow still reports 1 when saturated.
- Zero is computed from the final S, so an unsigned saturated subtract gives Zero=1.
- Flags and S update in the same cycle as out_valid.
- Mode bits are sampled per beat; mixing modes in consecutive beats is legal.
- STAGES=1: the registered single-stage form, latency 1.

Test Plan:
- Reset mid-flight: accept 2 beats, pull rst_n low for 1 cycle -> out_valid stays 0, S=0, flags 0; next beat after release emerges alone after 2 cycles.
- Signed add 0x7FFFFFFF+1 (Sat=0) -> S=0x80000000, Overflow=1, Negative=0, Zero=0. Same with Sat=1 -> S=0x7FFFFFFF, Overflow=1.
- Unsigned sub 5-7: Sat=0 -> S=0xFFFFFFFE, Overflow=1, Negative=1. Sat=1 -> S=0, Zero=1.
- Unsigned add 0xFFFFFFFF+1 -> S=0, Zero=1, Overflow=1, Negative=0. Signed sub 0x80000000-1 -> S=0x7FFFFFFF, Overflow=1, Negative=1.
- Cross-segment carry: A=0x0000FFFF, B=1, add -> S=0x00010000 exactly 2 cycles after acceptance, flags 0.
- Backpressure: stream 6 back-to-back beats A=i, B=i; hold out_ready=0 for 3 cycles mid-stream -> in_ready drops, outputs hold, results 0,2,4,6,8,10 each delivered once, in order.

Source files
------------

// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - pipelined integer adder/subtractor with saturation and flags
//
// Carry chain split into STAGES segments of WIDTH/STAGES bits, one register
// per segment; result and flags leave through the last register.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (A, B, Signed, Sub, Sat)
//   out_valid / out_ready result beat handshake (S, Zero, Overflow, Negative)
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Signed,
    input  logic             Sub,
    input  logic             Sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Zero,
    output logic             Overflow,
    output logic             Negative
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    // at least one intermediate slot so the arrays stay legal for STAGES=1
    localparam int NP   = (STAGES > 1) ? STAGES - 1 : 1;

    // intermediate pipeline registers (between segment k and k+1)
    logic             r_v   [NP];
    logic [WIDTH-1:0] r_a   [NP];
    logic [WIDTH-1:0] r_b   [NP];
    logic [WIDTH-1:0] r_r   [NP];
    logic             r_c   [NP];
    logic             r_sgn [NP];
    logic             r_sub [NP];
    logic             r_sat [NP];

    // per-segment inputs and results
    logic             w_v_in   [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_r_in   [STAGES];
    logic             w_c_in   [STAGES];
    logic             w_sgn_in [STAGES];
    logic             w_sub_in [STAGES];
    logic             w_sat_in [STAGES];
    logic [SEG:0]     w_sum    [STAGES];
    logic [WIDTH-1:0] w_r_out  [STAGES];

    logic             w_adv;
    logic [WIDTH-1:0] w_raw;
    logic             w_cy;
    logic             w_a_msb;
    logic             w_b_msb;
    logic             w_ovf;
    logic             w_neg;
    logic [WIDTH-1:0] w_s;

    // the whole pipe moves as one; it only stalls when a result is stuck
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // segment 0 is fed from the ports (B inverted and carry-in set for subtract),
    // later segments from the previous register
    always_comb begin
        w_v_in[0]   = in_valid;
        w_a_in[0]   = A;
        w_b_in[0]   = Sub ? ~B : B;
        w_r_in[0]   = '0;
        w_c_in[0]   = Sub;
        w_sgn_in[0] = Signed;
        w_sub_in[0] = Sub;
        w_sat_in[0] = Sat;
        for (int k = 1; k < STAGES; k++) begin
            w_v_in[k]   = r_v[k-1];
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_r_in[k]   = r_r[k-1];
            w_c_in[k]   = r_c[k-1];
            w_sgn_in[k] = r_sgn[k-1];
            w_sub_in[k] = r_sub[k-1];
            w_sat_in[k] = r_sat[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_sum[k] = {1'b0, w_a_in[k][k*SEG +: SEG]}
                     + {1'b0, w_b_in[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_c_in[k]};
            w_r_out[k] = w_r_in[k];
            w_r_out[k][k*SEG +: SEG] = w_sum[k][SEG-1:0];
        end
    end

    // flags and saturation on the completed sum, registered with out_valid
    always_comb begin
        w_raw   = w_r_out[LAST];
        w_cy    = w_sum[LAST][SEG];
        w_a_msb = w_a_in[LAST][WIDTH-1];
        w_b_msb = w_b_in[LAST][WIDTH-1];
        if (w_sgn_in[LAST]) begin
            w_ovf = (w_a_msb == w_b_msb) & (w_raw[WIDTH-1] != w_a_msb);
            // with differing signs no overflow is possible, so R's sign is true;
            // with equal signs the true sign is the shared operand sign
            w_neg = (w_a_msb ^ w_b_msb) ? w_raw[WIDTH-1] : w_a_msb;
        end else begin
            w_ovf = w_sub_in[LAST] ? ~w_cy : w_cy;
            w_neg = w_sub_in[LAST] & ~w_cy;
        end
        if (w_sat_in[LAST] & w_ovf) begin
            if (w_sgn_in[LAST])
                w_s = w_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else
                w_s = w_sub_in[LAST] ? '0 : '1;
        end else begin
            w_s = w_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NP; k++) begin
                r_v[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_r[k]   <= '0;
                r_c[k]   <= 1'b0;
                r_sgn[k] <= 1'b0;
                r_sub[k] <= 1'b0;
                r_sat[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            S         <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            Negative  <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r_v[k]   <= w_v_in[k];
                r_a[k]   <= w_a_in[k];
                r_b[k]   <= w_b_in[k];
                r_r[k]   <= w_r_out[k];
                r_c[k]   <= w_sum[k][SEG];
                r_sgn[k] <= w_sgn_in[k];
                r_sub[k] <= w_sub_in[k];
                r_sat[k] <= w_sat_in[k];
            end
            out_valid <= w_v_in[LAST];
            S         <= w_s;
            Zero      <= (w_s == '0);
            Overflow  <= w_ovf;
            Negative  <= w_neg;
        end
    end

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - self-checking bench for add_sub_pipe
module tb_add_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Signed;
    logic        Sub;
    logic        Sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] S;
    logic        Zero;
    logic        Overflow;
    logic        Negative;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        sub;
        logic        sat;
        logic [31:0] s;
        logic        z;
        logic        o;
        logic        n;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] got_q [$];

    add_sub_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Signed    (Signed),
        .Sub       (Sub),
        .Sat       (Sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .Negative  (Negative)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic sub, input logic sat);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Signed   = sgn;
        Sub      = sub;
        Sat      = sat;
    endtask

    initial begin
        logic [31:0] held;
        int          i;
        int          cnt;
        int          first;
        logic        acc;

        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{32'h00000003, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h00000005, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h23456789, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{32'h00000009, 32'h00000009, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A = '0; B = '0; Signed = 1'b0; Sub = 1'b0; Sat = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_S",         S,                  32'd0);
        chk("rst_Zero",      {31'b0, Zero},      32'd0);
        chk("rst_Overflow",  {31'b0, Overflow},  32'd0);
        chk("rst_Negative",  {31'b0, Negative},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // table-driven vectors, one beat at a time
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            drive(vecs[v].a, vecs[v].b, vecs[v].sgn, vecs[v].sub, vecs[v].sat);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            for (int t = 0; t < 10 && !out_valid; t++) @(negedge clk);
            chk($sformatf("v%0d_valid", v), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_S", v), S, vecs[v].s);
            chk($sformatf("v%0d_Zero", v), {31'b0, Zero}, {31'b0, vecs[v].z});
            chk($sformatf("v%0d_Overflow", v), {31'b0, Overflow}, {31'b0, vecs[v].o});
            chk($sformatf("v%0d_Negative", v), {31'b0, Negative}, {31'b0, vecs[v].n});
        end

        // cross-segment carry with exact latency
        @(negedge clk);
        drive(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_early_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_S", S, 32'h00010000);
        chk("lat_flags", {29'b0, Zero, Overflow, Negative}, 32'd0);
        @(negedge clk);

        // reset mid-flight
        drive(32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'h2, 32'h2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_S", S, 32'd0);
        chk("mid_rst_flags", {29'b0, Zero, Overflow, Negative}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rel_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("mid_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_post_valid", {31'b0, out_valid}, 32'd0);
        drive(32'h10, 32'h20, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        cnt   = 0;
        first = -1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                if (first < 0) begin
                    first = t;
                    chk("mid_beat_S", S, 32'h30);
                end
                cnt++;
            end
        end
        chk("mid_beat_count", cnt, 32'd1);
        chk("mid_beat_latency", first, 32'd1);

        // backpressure: 6 beats A=i, B=i, out_ready low for cycles 3..5
        i    = 0;
        held = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 5);
            if (i < 6) drive(i, i, 1'b0, 1'b0, 1'b0);
            else       in_valid = 1'b0;
            #1;
            if (out_valid && out_ready) got_q.push_back(S);
            if (c >= 3 && c <= 5) begin
                chk($sformatf("bp_in_ready_c%0d", c), {31'b0, in_ready}, 32'd0);
                chk($sformatf("bp_valid_c%0d", c), {31'b0, out_valid}, 32'd1);
                if (c == 3) held = S;
                else        chk($sformatf("bp_hold_c%0d", c), S, held);
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_accepted", i, 32'd6);
        chk("bp_count", got_q.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < got_q.size()) chk($sformatf("bp_result%0d", k), got_q[k], 2 * k);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
